// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG DCT sequencer and its slot counter.
package jpeg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PASS1,
    DRAIN1,
    PASS2,
    DRAIN2,
    DONE
  } seq_state_t;

  // One row of N pixels occupies N/2 cycles of the datapath.
  function automatic int slot_len(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/jpeg_slot_cnt.sv
// Slot (c), row (r) and block (b) counters for the DCT sequencer, with wrap and last-flags.
module jpeg_slot_cnt #(
  parameter int SLOT = 4,
  parameter int ROWS = 8,
  parameter int CW   = 2,
  parameter int RW   = 3,
  parameter int BW   = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          step,
  input  logic          next_blk,
  output logic [CW-1:0] c,
  output logic [RW-1:0] r,
  output logic [BW-1:0] b,
  output logic          c_last,
  output logic          r_last
);

  assign c_last = (c == CW'(SLOT - 1));
  assign r_last = (r == RW'(ROWS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      c <= '0;
      r <= '0;
      b <= '0;
    end else begin
      if (step) begin
        c <= c_last ? '0 : c + CW'(1);
        if (c_last) r <= r_last ? '0 : r + RW'(1);
      end
      if (next_blk) b <= b + BW'(1);
    end
  end

endmodule

// File: rtl/jpeg_dct_seq.sv
// Sequencer for the JPEG 2-D DCT/quantiser datapath: per block a row pass then a column pass.
// Build option JPEG_DCT_SEQ_PERF_EN adds cycles_o, the busy-cycle count of the last completed run.
module jpeg_dct_seq
  import jpeg_pkg::*;
#(
  parameter int N        = 8,
  parameter int ROW_LAT  = 4,
  parameter int BLOCKS   = 4,
  parameter int IN_AW    = 9,
  parameter int OUT_AW   = 9,
  localparam int BW      = ($clog2(BLOCKS) > 0) ? $clog2(BLOCKS) : 1,
  localparam int SW      = $clog2(N / 2),
  localparam int QW      = $clog2(N * N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [BW-1:0]     nblk_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              in_rden_o,
  output logic [IN_AW-1:0]  in_addr_o,
  output logic              dct_en_o,
  output logic              dct_mux_o,
  output logic              tr_wr_o,
  output logic              tr_rd_o,
  output logic              out_we_o,
  output logic [OUT_AW-1:0] out_addr_o,
  output logic [SW-1:0]     out_sel_o,
  output logic [QW-1:0]     q_idx_o
`ifdef JPEG_DCT_SEQ_PERF_EN
  ,
  output logic [15:0]       cycles_o
`endif
);

  localparam int SLOT = slot_len(N);
  localparam int CW   = $clog2(SLOT);
  localparam int RW   = $clog2(N);
  localparam int DW   = $clog2(ROW_LAT + 2);

  seq_state_t    state, state_nx;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [BW-1:0] b, nblk_q;
  logic [DW-1:0] dcnt;
  logic          c_last, r_last, drain_last, accept;
  logic          cnt_clr, cnt_step, cnt_blk;

  jpeg_slot_cnt #(.SLOT(SLOT), .ROWS(N), .CW(CW), .RW(RW), .BW(BW)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (cnt_clr),
    .step     (cnt_step),
    .next_blk (cnt_blk),
    .c        (c),
    .r        (r),
    .b        (b),
    .c_last   (c_last),
    .r_last   (r_last)
  );

  // start_i is a request, not a held handshake: it is taken only in IDLE with abort_i low;
  // completion is signalled by a single done_o pulse, and abort_i overrides everything.
  assign accept     = (state == IDLE) && start_i && !abort_i;
  assign drain_last = (dcnt == DW'(ROW_LAT));

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    cnt_blk  = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        state_nx = PASS1;
        cnt_clr  = 1'b1;
      end
      PASS1: begin
        cnt_step = 1'b1;
        if (c_last && r_last) state_nx = DRAIN1;
      end
      DRAIN1: if (drain_last) state_nx = PASS2;
      PASS2: begin
        cnt_step = 1'b1;
        if (c_last && r_last) state_nx = DRAIN2;
      end
      DRAIN2: if (drain_last) begin
        if (b < nblk_q) begin
          state_nx = PASS1;
          cnt_blk  = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_i) begin
      state_nx = IDLE;
      cnt_clr  = 1'b1;
      cnt_step = 1'b0;
      cnt_blk  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      nblk_q <= '0;
      dcnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) nblk_q <= (32'(nblk_i) > 32'(BLOCKS - 1)) ? BW'(BLOCKS - 1) : nblk_i;
      dcnt <= ((state == DRAIN1 || state == DRAIN2) && !drain_last) ? dcnt + DW'(1) : '0;
    end
  end

  logic dct_en;
  assign dct_en = (state == PASS1 && c == CW'(N / 4)) || (state == PASS2 && c == CW'(1));

  // Each issue travels ROW_LAT cycles carrying its pass, row and block so the late
  // strobes still know which row they belong to after the counters have moved on.
  logic [ROW_LAT-1:0] dv, dp2;
  logic [RW-1:0]      dr [ROW_LAT];
  logic [BW-1:0]      db [ROW_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      dv  <= '0;
      dp2 <= '0;
      for (int i = 0; i < ROW_LAT; i++) begin
        dr[i] <= '0;
        db[i] <= '0;
      end
    end else begin
      dv[0]  <= dct_en;
      dp2[0] <= (state == PASS2);
      dr[0]  <= r;
      db[0]  <= b;
      for (int i = 1; i < ROW_LAT; i++) begin
        dv[i]  <= dv[i-1];
        dp2[i] <= dp2[i-1];
        dr[i]  <= dr[i-1];
        db[i]  <= db[i-1];
      end
    end
  end

  logic          tap_v, tap_p2, wr_start, wr_act;
  logic [SW-1:0] wr_p, cur_p;
  logic [RW-1:0] wr_r, cur_r;
  logic [BW-1:0] wr_b, cur_b;

  assign tap_v    = dv[ROW_LAT-1];
  assign tap_p2   = dp2[ROW_LAT-1];
  assign wr_start = tap_v && tap_p2;

  // The first write of a burst is driven straight from the tap; the register covers the rest.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      wr_act <= 1'b0;
      wr_p   <= '0;
      wr_r   <= '0;
      wr_b   <= '0;
    end else if (wr_start) begin
      wr_act <= 1'b1;
      wr_p   <= SW'(1);
      wr_r   <= dr[ROW_LAT-1];
      wr_b   <= db[ROW_LAT-1];
    end else if (wr_act) begin
      if (wr_p == SW'(SLOT - 1)) wr_act <= 1'b0;
      wr_p <= wr_p + SW'(1);
    end
  end

  assign cur_p = wr_start ? '0 : wr_p;
  assign cur_r = wr_start ? dr[ROW_LAT-1] : wr_r;
  assign cur_b = wr_start ? db[ROW_LAT-1] : wr_b;

  assign busy_o     = (state != IDLE) && (state != DONE);
  assign done_o     = (state == DONE);
  assign in_rden_o  = (state == PASS1) && (c < CW'(N / 4));
  assign in_addr_o  = in_rden_o ? IN_AW'((32'(b) * N + 32'(r)) * (N / 4) + 32'(c)) : '0;
  assign dct_en_o   = dct_en;
  assign dct_mux_o  = (state == PASS2);
  assign tr_wr_o    = tap_v && !tap_p2;
  assign tr_rd_o    = (state == PASS2) && (c == '0);
  assign out_we_o   = wr_start || wr_act;
  assign out_addr_o = out_we_o ? OUT_AW'((32'(cur_b) * N + 32'(cur_r)) * (N / 2) + 32'(cur_p)) : '0;
  assign out_sel_o  = out_we_o ? cur_p : '0;
  assign q_idx_o    = out_we_o ? QW'(32'(cur_r) * N + 2 * 32'(cur_p)) : '0;

`ifdef JPEG_DCT_SEQ_PERF_EN
  logic [15:0] run_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt  <= '0;
      cycles_o <= '0;
    end else begin
      if (accept) run_cnt <= '0;
      else if (busy_o && run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
      if (done_o) cycles_o <= run_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_dct_seq.sv
// Directed bench for jpeg_dct_seq (N=8, ROW_LAT=4, BLOCKS=4): vector table plus corner sequences.
module tb_jpeg_dct_seq;

  localparam int N       = 8;
  localparam int ROW_LAT = 4;
  localparam int IN_AW   = 9;
  localparam int OUT_AW  = 9;

  logic              clk = 1'b0;
  logic              rst_i, start_i, abort_i;
  logic [1:0]        nblk_i;
  logic              busy_o, done_o, in_rden_o, dct_en_o, dct_mux_o, tr_wr_o, tr_rd_o, out_we_o;
  logic [IN_AW-1:0]  in_addr_o;
  logic [OUT_AW-1:0] out_addr_o;
  logic [1:0]        out_sel_o;
  logic [5:0]        q_idx_o;
`ifdef JPEG_DCT_SEQ_PERF_EN
  logic [15:0]       cycles;
`endif

  jpeg_dct_seq dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .nblk_i     (nblk_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_rden_o  (in_rden_o),
    .in_addr_o  (in_addr_o),
    .dct_en_o   (dct_en_o),
    .dct_mux_o  (dct_mux_o),
    .tr_wr_o    (tr_wr_o),
    .tr_rd_o    (tr_rd_o),
    .out_we_o   (out_we_o),
    .out_addr_o (out_addr_o),
    .out_sel_o  (out_sel_o),
    .q_idx_o    (q_idx_o)
`ifdef JPEG_DCT_SEQ_PERF_EN
    ,
    .cycles_o   (cycles)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [IN_AW-1:0]  in_exp_q[$];
  logic [OUT_AW-1:0] exp_q[$];
  logic [5:0]        q_exp_q[$];

  typedef struct {
    int nblk;
    int exp_done;
    int exp_busy;
    int exp_rden;
    int exp_we;
    int exp_trwr;
    int mid_start;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int idle_bad();
    return (busy_o | done_o | in_rden_o | dct_en_o | dct_mux_o | tr_wr_o | tr_rd_o | out_we_o |
            (|in_addr_o) | (|out_addr_o) | (|out_sel_o) | (|q_idx_o)) ? 1 : 0;
  endfunction

  // Driver: the posedge following start_i=1 is the accept edge; cycle 1 is the next one.
  task automatic do_start(input int nblk);
    @(negedge clk);
    start_i = 1'b1;
    nblk_i  = 2'(nblk);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic run_check(input vec_t v);
    int done_cyc, n_rden, n_we, n_trwr, n_trrd, n_en, n_en2, n_busy;
    int first_we, first_trwr, first_trrd, last_en1, last_en2;
    int e;
    in_exp_q.delete();
    exp_q.delete();
    q_exp_q.delete();
    for (int k = 0; k < 16 * (v.nblk + 1); k++) in_exp_q.push_back(IN_AW'(k));
    for (int k = 0; k < 32 * (v.nblk + 1); k++) begin
      exp_q.push_back(OUT_AW'(k));
      q_exp_q.push_back(6'(((k % 32) / 4) * 8 + 2 * (k % 4)));
    end
    done_cyc = -1; n_rden = 0; n_we = 0; n_trwr = 0; n_trrd = 0; n_en = 0; n_en2 = 0; n_busy = 0;
    first_we = -1; first_trwr = -1; first_trrd = -1; last_en1 = -100; last_en2 = -100;
    do_start(v.nblk);
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (cyc == v.mid_start) begin
        start_i = 1'b1;
        nblk_i  = 2'd3;
      end
      if (busy_o) n_busy++;
      if (in_rden_o) begin
        n_rden++;
        if (in_exp_q.size() == 0) check("in_addr_extra", int'(in_addr_o), -1);
        else check("in_addr", int'(in_addr_o), int'(in_exp_q.pop_front()));
      end
      if (tr_wr_o) begin
        n_trwr++;
        if (first_trwr < 0) first_trwr = cyc;
        check("trwr_lat", cyc - last_en1, ROW_LAT);
      end
      if (tr_rd_o) begin
        n_trrd++;
        if (first_trrd < 0) first_trrd = cyc;
      end
      if (out_we_o) begin
        n_we++;
        if (first_we < 0) first_we = cyc;
        if (exp_q.size() == 0) check("out_addr_extra", int'(out_addr_o), -1);
        else begin
          e = int'(exp_q.pop_front());
          check("out_addr", int'(out_addr_o), e);
          check("out_sel", int'(out_sel_o), e % 4);
          check("q_idx", int'(q_idx_o), int'(q_exp_q.pop_front()));
          if (e % 4 == 0) check("we_lat", cyc - last_en2, ROW_LAT);
        end
      end
      if (dct_en_o) begin
        n_en++;
        if (dct_mux_o) begin
          n_en2++;
          last_en2 = cyc;
        end else begin
          last_en1 = cyc;
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        check("busy_at_done", int'(busy_o), 0);
      end
    end
    check("done_cycle", done_cyc, v.exp_done);
    check("busy_cycles", n_busy, v.exp_busy);
    check("rden_count", n_rden, v.exp_rden);
    check("we_count", n_we, v.exp_we);
    check("trwr_count", n_trwr, v.exp_trwr);
    check("trrd_count", n_trrd, v.exp_trwr);
    check("dct_en_count", n_en, 2 * v.exp_trwr);
    check("dct_en_pass2", n_en2, v.exp_trwr);
    check("first_trwr", first_trwr, 7);
    check("first_trrd", first_trrd, 38);
    check("first_we", first_we, 43);
    check("out_q_left", exp_q.size(), 0);
  endtask

  initial begin
    int bad, dones;
    vecs[0] = '{nblk: 0, exp_done: 75,  exp_busy: 74,  exp_rden: 16, exp_we: 32,  exp_trwr: 8,  mid_start: 0};
    vecs[1] = '{nblk: 3, exp_done: 297, exp_busy: 296, exp_rden: 64, exp_we: 128, exp_trwr: 32, mid_start: 0};
    vecs[2] = '{nblk: 1, exp_done: 149, exp_busy: 148, exp_rden: 32, exp_we: 64,  exp_trwr: 16, mid_start: 0};
    vecs[3] = '{nblk: 2, exp_done: 223, exp_busy: 222, exp_rden: 48, exp_we: 96,  exp_trwr: 24, mid_start: 0};
    vecs[4] = '{nblk: 0, exp_done: 75,  exp_busy: 74,  exp_rden: 16, exp_we: 32,  exp_trwr: 8,  mid_start: 50};

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; nblk_i = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", idle_bad(), 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_reset_idle", idle_bad(), 0);

    for (int i = 0; i < 5; i++) begin
      run_check(vecs[i]);
`ifdef JPEG_DCT_SEQ_PERF_EN
      if (vecs[i].nblk == 1) check("cycles_o", int'(cycles), 148);
`endif
    end

    // Abort in PASS2: strobes drop the next cycle and no done follows.
    do_start(0);
    repeat (39) @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", int'(busy_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_next_cycle", idle_bad(), 0);
    bad = 0; dones = 0;
    repeat (100) begin
      @(negedge clk);
      bad += idle_bad();
      dones += int'(done_o);
    end
    check("abort_quiet", bad, 0);
    check("abort_no_done", dones, 0);
    run_check(vecs[0]);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; abort_i = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += idle_bad();
    end
    check("start_abort_ignored", bad, 0);

    // Reset in the middle of a run.
    do_start(1);
    repeat (20) @(negedge clk);
    check("rst_busy_before", int'(busy_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", idle_bad(), 0);
`ifdef JPEG_DCT_SEQ_PERF_EN
    check("rst_cycles_o", int'(cycles), 0);
`endif
    rst_i = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += idle_bad();
    end
    check("rst_quiet", bad, 0);
    run_check(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
